// File: rtl/bsg_sdr_link_reset_pkg.sv
// Shared types and helpers for the SDR link reset sequencer: sequence states,
// the four-bit per-link reset bundle and the per-phase reset encodings.
package bsg_sdr_link_reset_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAssertAll,
        StRelUplink,
        StRelDownlink,
        StTokenPulse,
        StRelDownstream,
        StDone
    } seq_state_e;

    // Bit order matches manual_resets_i: {uplink, downlink, downstream, token}.
    typedef struct packed {
        logic uplink;
        logic downlink;
        logic downstream;
        logic token;
    } link_rst_t;

    localparam link_rst_t IdleResets = '{uplink: 1'b1, downlink: 1'b1, downstream: 1'b1,
                                         token: 1'b0};
    localparam link_rst_t ReleasedResets = '{uplink: 1'b0, downlink: 1'b0, downstream: 1'b0,
                                             token: 1'b0};

    function automatic link_rst_t phase_resets(seq_state_e st);
        link_rst_t r;
        r = IdleResets;
        unique case (st)
            StIdle:          r = IdleResets;
            StAssertAll:     r = IdleResets;
            StRelUplink:     r = '{uplink: 1'b0, downlink: 1'b1, downstream: 1'b1, token: 1'b0};
            StRelDownlink:   r = '{uplink: 1'b0, downlink: 1'b0, downstream: 1'b1, token: 1'b0};
            StTokenPulse:    r = '{uplink: 1'b0, downlink: 1'b0, downstream: 1'b1, token: 1'b1};
            StRelDownstream: r = ReleasedResets;
            StDone:          r = ReleasedResets;
            default:         r = IdleResets;
        endcase
        return r;
    endfunction

    function automatic seq_state_e next_phase(seq_state_e st);
        seq_state_e n;
        n = StIdle;
        unique case (st)
            StAssertAll:     n = StRelUplink;
            StRelUplink:     n = StRelDownlink;
            StRelDownlink:   n = StTokenPulse;
            StTokenPulse:    n = StRelDownstream;
            StRelDownstream: n = StDone;
            default:         n = StIdle;
        endcase
        return n;
    endfunction

    function automatic logic in_phase(seq_state_e st);
        return (st == StAssertAll) || (st == StRelUplink) || (st == StRelDownlink) ||
               (st == StTokenPulse) || (st == StRelDownstream);
    endfunction

endpackage

// File: rtl/bsg_sdr_reset_phase_counter.sv
// Per-phase hold counter: loads a hold value, counts down while enabled and
// flags the final cycle of the phase when the count reaches one.
module bsg_sdr_reset_phase_counter #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [width_p-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == width_p'(1));

endmodule

// File: rtl/bsg_sdr_link_reset_sequencer.sv
// Sequences uplink/downlink/token/downstream resets for a set of SDR links,
// with a manual override that drives the resets directly.
module bsg_sdr_link_reset_sequencer
    import bsg_sdr_link_reset_pkg::*;
#(
    parameter int unsigned num_links_p  = 3,
    parameter int unsigned hold_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [num_links_p-1:0]  link_en_i,
    input  logic [hold_width_p-1:0] hold_cycles_i,
    input  logic                    manual_i,
    input  logic [3:0]              manual_resets_i,
    output logic [num_links_p-1:0]  uplink_reset_o,
    output logic [num_links_p-1:0]  downlink_reset_o,
    output logic [num_links_p-1:0]  downstream_reset_o,
    output logic [num_links_p-1:0]  token_reset_o,
    output logic                    busy_o,
    output logic                    done_o
);

    seq_state_e              state_d, state_q;
    logic [num_links_p-1:0]  mask_d, mask_q;
    logic [hold_width_p-1:0] hold_d, hold_q;
    logic [hold_width_p-1:0] hold_eff;
    logic                    busy_d, busy_q;
    logic                    done_d, done_q;
    logic                    accept;
    logic                    cnt_load;
    logic [hold_width_p-1:0] cnt_load_val;
    logic                    cnt_en;
    logic                    cnt_expire;

    // A zero hold would never expire, so it runs as a one-cycle phase.
    assign hold_eff = (hold_cycles_i == '0) ? hold_width_p'(1) : hold_cycles_i;

    assign accept = start_i && !manual_i && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        hold_d       = hold_q;
        cnt_load     = 1'b0;
        cnt_load_val = hold_q;
        cnt_en       = 1'b0;

        if (manual_i) begin
            state_d      = StIdle;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
        end else if (accept) begin
            state_d      = StAssertAll;
            mask_d       = link_en_i;
            hold_d       = hold_eff;
            cnt_load     = 1'b1;
            cnt_load_val = hold_eff;
        end else if (in_phase(state_q)) begin
            cnt_en = 1'b1;
            if (cnt_expire) begin
                state_d = next_phase(state_q);
                // Reload for the following phase; the last phase just drains to zero.
                if (state_d != StDone) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = hold_q;
                end
            end
        end

        busy_d = in_phase(state_d);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    bsg_sdr_reset_phase_counter #(
        .width_p (hold_width_p)
    ) u_phase_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .expire_o   (cnt_expire)
    );

    // Outputs are computed from the next state so they change on state entry.
    for (genvar i = 0; i < num_links_p; i++) begin : g_link
        link_rst_t link_d, link_q;

        always_comb begin
            link_d = IdleResets;
            if (manual_i) begin
                link_d = link_rst_t'(manual_resets_i);
            end else if (mask_d[i]) begin
                link_d = phase_resets(state_d);
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                link_q <= IdleResets;
            end else begin
                link_q <= link_d;
            end
        end

        assign uplink_reset_o[i]     = link_q.uplink;
        assign downlink_reset_o[i]   = link_q.downlink;
        assign downstream_reset_o[i] = link_q.downstream;
        assign token_reset_o[i]      = link_q.token;
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// Directed self-checking bench for the SDR link reset sequencer.
module tb_bsg_sdr_link_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] link_en;
    logic [7:0] hold_cycles;
    logic       manual;
    logic [3:0] manual_resets;
    logic [2:0] uplink_rst, downlink_rst, downstream_rst, token_rst;
    logic       busy, done;

    int checks = 0;
    int failures = 0;

    bsg_sdr_link_reset_sequencer #(
        .num_links_p  (3),
        .hold_width_p (8)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .start_i            (start),
        .link_en_i          (link_en),
        .hold_cycles_i      (hold_cycles),
        .manual_i           (manual),
        .manual_resets_i    (manual_resets),
        .uplink_reset_o     (uplink_rst),
        .downlink_reset_o   (downlink_rst),
        .downstream_reset_o (downstream_rst),
        .token_reset_o      (token_rst),
        .busy_o             (busy),
        .done_o             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start; returns in cycle 1 (first cycle of ASSERT_ALL).
    task automatic do_start(input logic [2:0] mask, input logic [7:0] h);
        link_en     = mask;
        hold_cycles = h;
        start       = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [3:0] link_bits(int i);
        return {uplink_rst[i], downlink_rst[i], downstream_rst[i], token_rst[i]};
    endfunction

    // Expected {up,down,downstream,token} of an enabled link, cycle c after start.
    function automatic logic [3:0] exp_bits(int c, int h);
        int p;
        p = (c - 1) / h;
        case (p)
            0: return 4'b1110;
            1: return 4'b0110;
            2: return 4'b0010;
            3: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic exp_busy(int c, int h);
        return ((c - 1) / h) < 5;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link_bits(i) !== 4'b1110) begin
                failures++;
                $display("FAIL reset_link%0d got=%b exp=%b", i, link_bits(i), 4'b1110);
            end
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
        end
        step();
        checks++;
        if (link_bits(0) !== 4'b1110 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b busy=%b exp=1110 busy=0", link_bits(0), busy);
        end
    endtask

    task automatic test_full_seq();
        do_start(3'b111, 8'd4);
        for (int c = 1; c <= 22; c++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (link_bits(i) !== exp_bits(c, 4)) begin
                    failures++;
                    $display("FAIL full_c%0d_link%0d got=%b exp=%b", c, i, link_bits(i),
                             exp_bits(c, 4));
                end
            end
            checks++;
            if (busy !== exp_busy(c, 4) || done !== !exp_busy(c, 4)) begin
                failures++;
                $display("FAIL full_c%0d_status got busy=%b done=%b exp busy=%b", c, busy, done,
                         exp_busy(c, 4));
            end
            if (c < 22) step();
        end
    endtask

    task automatic test_mask();
        do_start(3'b010, 8'd2);
        for (int c = 1; c <= 12; c++) begin
            for (int i = 0; i < 3; i++) begin
                logic [3:0] e;
                e = (i == 1) ? exp_bits(c, 2) : 4'b1110;
                checks++;
                if (link_bits(i) !== e) begin
                    failures++;
                    $display("FAIL mask_c%0d_link%0d got=%b exp=%b", c, i, link_bits(i), e);
                end
            end
            checks++;
            if (done !== (c >= 11)) begin
                failures++;
                $display("FAIL mask_c%0d_done got=%b exp=%b", c, done, (c >= 11));
            end
            if (c < 12) step();
        end
    endtask

    task automatic test_hold_zero();
        do_start(3'b111, 8'd0);
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (link_bits(2) !== exp_bits(c, 1) || done !== (c >= 6) || busy !== (c < 6)) begin
                failures++;
                $display("FAIL hold0_c%0d got=%b busy=%b done=%b exp=%b done=%b", c,
                         link_bits(2), busy, done, exp_bits(c, 1), (c >= 6));
            end
            if (c < 7) step();
        end
    endtask

    task automatic test_start_ignored_and_restart();
        do_start(3'b111, 8'd3);
        for (int c = 1; c <= 17; c++) begin
            // Cycle 7 is the first REL_DOWNLINK cycle for hold 3.
            start = (c == 7);
            checks++;
            if (link_bits(0) !== exp_bits(c, 3) || done !== (c >= 16)) begin
                failures++;
                $display("FAIL ignore_c%0d got=%b done=%b exp=%b done=%b", c, link_bits(0), done,
                         exp_bits(c, 3), (c >= 16));
            end
            step();
        end
        start = 1'b0;
        // Still in DONE; restart and expect all resets reasserted the next cycle.
        do_start(3'b111, 8'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link_bits(i) !== 4'b1110) begin
                failures++;
                $display("FAIL restart_link%0d got=%b exp=1110", i, link_bits(i));
            end
        end
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL restart_status got=%b exp=10", {busy, done});
        end
        for (int c = 2; c <= 16; c++) step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got=%b exp=1", done);
        end
    endtask

    task automatic test_manual();
        do_start(3'b101, 8'd2);
        for (int c = 1; c < 7; c++) step();
        checks++;
        if (link_bits(0) !== 4'b0011 || link_bits(1) !== 4'b1110) begin
            failures++;
            $display("FAIL manual_pre got l0=%b l1=%b exp l0=0011 l1=1110", link_bits(0),
                     link_bits(1));
        end
        manual        = 1'b1;
        manual_resets = 4'b0101;
        start         = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link_bits(i) !== 4'b0101) begin
                failures++;
                $display("FAIL manual_link%0d got=%b exp=0101", i, link_bits(i));
            end
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL manual_status got=%b exp=00", {busy, done});
        end
        manual_resets = 4'b1010;
        step();
        checks++;
        if (link_bits(1) !== 4'b1010 || busy !== 1'b0) begin
            failures++;
            $display("FAIL manual_follow got=%b busy=%b exp=1010 busy=0", link_bits(1), busy);
        end
        manual = 1'b0;
        start  = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (link_bits(i) !== 4'b1110) begin
                failures++;
                $display("FAIL manual_exit_link%0d got=%b exp=1110", i, link_bits(i));
            end
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL manual_exit_status got=%b exp=00", {busy, done});
        end
    endtask

    task automatic test_reset_mid();
        do_start(3'b111, 8'd4);
        for (int c = 1; c < 6; c++) step();
        checks++;
        if (link_bits(0) !== 4'b0110) begin
            failures++;
            $display("FAIL midrst_pre got=%b exp=0110", link_bits(0));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (link_bits(0) !== 4'b1110 || link_bits(2) !== 4'b1110 || {busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_values got l0=%b l2=%b bd=%b exp 1110 1110 00", link_bits(0),
                     link_bits(2), {busy, done});
        end
        step();
        do_start(3'b111, 8'd2);
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (link_bits(1) !== exp_bits(c, 2) || busy !== exp_busy(c, 2)) begin
                failures++;
                $display("FAIL midrst_seq_c%0d got=%b busy=%b exp=%b busy=%b", c, link_bits(1),
                         busy, exp_bits(c, 2), exp_busy(c, 2));
            end
            if (c < 11) step();
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        link_en       = 3'b000;
        hold_cycles   = 8'd0;
        manual        = 1'b0;
        manual_resets = 4'b0000;
        test_reset();
        test_full_seq();
        test_mask();
        test_hold_zero();
        test_start_ignored_and_restart();
        test_manual();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
